// File: rtl/modn_counter_pkg.sv
// Shared helpers for the modulo-N counter.
// Holds the counter-width function so every user of the counter sizes it the same way.
package modn_counter_pkg;

    // Bits needed to hold values 0..value-1. Never less than 1, so N=1 still gets a real port.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/modn_counter.sv
// Parameterised modulo-N event counter with a combinational carry-out on the terminal count.
// Used as a frame/bit timer in the LVDS serial receiver.
// Counter chains are built by feeding co of one instance into rst of the next.
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter int       N          = 24,
    parameter bit       IS_NEGEDGE = 1'b0,
    localparam int      CW         = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          co,
    output logic [CW-1:0] cnt
);

    // An unusable modulus must stop elaboration rather than build a broken counter.
    generate
        if (N < 1) begin : g_bad_modulus
            $fatal(1, "modn_counter: N must be >= 1");
        end
    endgenerate

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_at_last;

    // Terminal-count detect and carry-out. co is unregistered so a parent can use it
    // in the same cycle (load strobe, or reset of a downstream counter).
    always_comb begin
        w_at_last = (r_cnt == LAST);
        co        = ~rst & en & w_at_last;
    end

    // Next count when enabled. The wrap logic depends on the modulus.
    generate
        if (N == 1) begin : g_next_single
            // Only one legal value, so the count never moves.
            always_comb begin
                w_cnt_next = '0;
            end
        end else if ((N & (N - 1)) == 0) begin : g_next_pow2
            // Binary overflow already wraps from N-1 to 0.
            always_comb begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end else begin : g_next_modn
            // Explicit wrap keeps the count below N for non-power-of-two moduli.
            always_comb begin
                w_cnt_next = w_at_last ? '0 : (r_cnt + CW'(1));
            end
        end
    endgenerate

    // Count register on the selected clock edge; rst wins over en.
    generate
        if (IS_NEGEDGE) begin : g_ff_neg
            always_ff @(negedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= w_cnt_next;
                end
            end
        end else begin : g_ff_pos
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (en) begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    endgenerate

    assign cnt = r_cnt;

endmodule

// File: tb/tb_modn_counter.sv
// Self-checking bench for modn_counter: five instances (N=24 rising, N=24 falling,
// N=1, N=48, N=3 reset by the N=48 carry) checked every cycle against a modulo-arithmetic
// model, plus directed scenarios with hand-computed expectations.
module tb_modn_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, rst_b, en_b;
    logic rst3;
    logic co24, co24n, co1, co48, co3;
    logic [4:0] cnt24, cnt24n;
    logic [0:0] cnt1;
    logic [5:0] cnt48;
    logic [1:0] cnt3;

    assign rst3 = rst_b | co48;

    modn_counter #(.N(24), .IS_NEGEDGE(1'b0)) u24  (.clk(clk), .rst(rst_a), .en(en_a), .co(co24),  .cnt(cnt24));
    modn_counter #(.N(24), .IS_NEGEDGE(1'b1)) u24n (.clk(clk), .rst(rst_a), .en(en_a), .co(co24n), .cnt(cnt24n));
    modn_counter #(.N(1),  .IS_NEGEDGE(1'b0)) u1   (.clk(clk), .rst(rst_a), .en(en_a), .co(co1),   .cnt(cnt1));
    modn_counter #(.N(48), .IS_NEGEDGE(1'b0)) u48  (.clk(clk), .rst(rst_b), .en(en_b), .co(co48),  .cnt(cnt48));
    modn_counter #(.N(3),  .IS_NEGEDGE(1'b0)) u3   (.clk(clk), .rst(rst3),  .en(en_b), .co(co3),   .cnt(cnt3));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_next(input int m, input int n, input bit r, input bit e);
        if (r) return 0;
        if (e) return (m + 1) % n;
        return m;
    endfunction

    function automatic int m_co(input int m, input int n, input bit r, input bit e);
        return (!r && e && (m == n - 1)) ? 1 : 0;
    endfunction

    int m24 = 0, m24n = 0, m1 = 0, m48 = 0, m3 = 0;
    int m_co48;
    always_comb m_co48 = m_co(m48, 48, rst_b, en_b);

    always @(posedge clk) begin
        m24 <= m_next(m24, 24, rst_a, en_a);
        m1  <= m_next(m1, 1, rst_a, en_a);
        m48 <= m_next(m48, 48, rst_b, en_b);
        m3  <= m_next(m3, 3, rst_b || (m_co48 != 0), en_b);
    end

    always @(negedge clk) begin
        m24n <= m_next(m24n, 24, rst_a, en_a);
    end

    // ---------------- per-cycle compare ----------------
    // Rising-edge instances are sampled on the falling edge; the falling-edge instance
    // is sampled on the rising edge, where its value must be stable.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cnt24", int'(cnt24), m24);
                check("co24", int'(co24), m_co(m24, 24, rst_a, en_a));
                check("cnt24_below_N", (int'(cnt24) < 24) ? 1 : 0, 1);
                check("cnt1", int'(cnt1), m1);
                check("co1", int'(co1), m_co(m1, 1, rst_a, en_a));
                check("cnt48", int'(cnt48), m48);
                check("co48", int'(co48), m_co48);
                check("cnt3", int'(cnt3), m3);
                check("co3", int'(co3), m_co(m3, 3, rst_b || (m_co48 != 0), en_b));
                check("cnt3_below_N", (int'(cnt3) < 3) ? 1 : 0, 1);
            end
            @(posedge clk);
            if (chk_en) begin
                check("cnt24n", int'(cnt24n), m24n);
                check("co24n", int'(co24n), m_co(m24n, 24, rst_a, en_a));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n24, first24, first48, first3, first_after_rst;
        bit found;

        rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
        repeat (3) tick();

        // Scenario 1: release reset, count continuously for 60 edges.
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset_cnt24", int'(cnt24), 0);
        check("reset_cnt48", int'(cnt48), 0);
        n24 = 0; first24 = 0; first48 = 0; first3 = 0;
        for (int k = 1; k <= 60; k++) begin
            #1;
            if (co24) begin
                n24++;
                if (first24 == 0) first24 = k;
            end
            if (co48 && first48 == 0) first48 = k;
            if (co3 && k > 48 && first3 == 0) first3 = k;
            tick();
        end
        check("co24_pulses_in_60", n24, 2);
        check("co24_first_edge", first24, 24);
        check("co48_first_edge", first48, 48);
        check("co3_first_after_co48", first3, 51);
        $display("scenario continuous count: co24 pulses=%0d first co24=%0d co48=%0d co3=%0d", n24, first24, first48, first3);

        // Scenario 2: N=48 held at terminal count with en low.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cnt48 == 6'd47) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wait_cnt48_eq_47", int'(found), 1);
        for (int i = 0; i < 5; i++) begin
            en_b = 1'b0;
            #1;
            check("gap_co48", int'(co48), 0);
            check("gap_cnt48", int'(cnt48), 47);
            tick();
        end
        en_b = 1'b1;
        #1;
        check("resume_co48", int'(co48), 1);
        tick();
        #1;
        check("resume_cnt48_wrap", int'(cnt48), 0);
        $display("scenario en gap at terminal count: cnt48=%0d", cnt48);

        // Scenario 3: reset mid-count at cnt=17.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cnt24 == 5'd17) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wait_cnt24_eq_17", int'(found), 1);
        rst_a = 1'b1;
        #1;
        check("midrst_co24", int'(co24), 0);
        tick();
        rst_a = 1'b0;
        #1;
        check("midrst_cnt24", int'(cnt24), 0);
        first_after_rst = 0;
        for (int k = 1; k <= 30; k++) begin
            #1;
            if (co24 && first_after_rst == 0) first_after_rst = k;
            tick();
        end
        check("co24_after_midrst", first_after_rst, 24);
        $display("scenario mid-count reset: next co24 at edge %0d", first_after_rst);

        // Scenario 4: N=1 with en toggling, then reset.
        for (int i = 0; i < 3; i++) begin
            en_a = (i != 1);
            #1;
            check("n1_co_follows_en", int'(co1), (i != 1) ? 1 : 0);
            check("n1_cnt", int'(cnt1), 0);
            tick();
        end
        rst_a = 1'b1; en_a = 1'b1;
        #1;
        check("n1_co_in_reset", int'(co1), 0);
        tick();
        rst_a = 1'b0;
        $display("scenario N=1 toggle: done");

        // Scenario 5: random enable/reset traffic on both input groups.
        for (int i = 0; i < 3000; i++) begin
            en_a  = ($urandom_range(0, 3) != 0);
            en_b  = ($urandom_range(0, 3) != 0);
            rst_a = ($urandom_range(0, 59) == 0);
            rst_b = ($urandom_range(0, 79) == 0);
            tick();
        end
        $display("scenario random: 3000 cycles");

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
